inst_amp_gain_ctrl: RTL and testbench

Digital auto-ranging and channel-scan controller for the multi-channel instrumentation amplifier macro. It drives the amplifier's input-mux select and programmable-gain select. It watches the analog window comparators (over-range and under-range) and adjusts gain per channel with settle and hysteresis timing. It emits one sample strobe per channel visit for the downstream ADC/readout logic.

---
 rtl/inst_amp_gain_ctrl.sv | 175 +++++++++++++++++
 tb/tb_inst_amp_gain_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_amp_gain_ctrl.sv
// Auto-ranging / channel-scan controller for the multi-channel instrumentation amplifier.
// Optional feature macro: OVR_COUNT_EN adds the saturating over-range event counter ovr_count.
module inst_amp_gain_ctrl #(
  parameter int NUM_CH        = 4,
  parameter int GAIN_BITS     = 3,
  parameter int SETTLE_CYCLES = 16,
  parameter int HYST_COUNT    = 4,
  localparam int CH_W         = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 cmp_hi,
  input  logic                 cmp_lo,
  input  logic                 auto_en,
  input  logic [GAIN_BITS-1:0] man_gain,
  input  logic                 scan_en,
  output logic [CH_W-1:0]      ch_sel,
  output logic [GAIN_BITS-1:0] gain_sel,
  output logic                 settled,
  output logic                 sample_strobe,
  output logic                 overrange,
`ifdef OVR_COUNT_EN
  output logic [7:0]           ovr_count,
`endif
  output logic [1:0]           state_dbg_o
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int EC_W  = $clog2(HYST_COUNT + 1);
  localparam logic [GAIN_BITS-1:0] GMAX = {GAIN_BITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EVAL   = 2'd2,
    NEXT   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           hi_sync_q, lo_sync_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [EC_W-1:0]      ecnt_q, ecnt_d;
  logic                 all_hi_q, all_hi_d;
  logic                 all_lo_q, all_lo_d;
  logic                 ovr_q, ovr_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [GAIN_BITS-1:0] g_q [NUM_CH];
  logic [GAIN_BITS-1:0] g_d [NUM_CH];

  logic                 hi_s, lo_s;
  logic                 hi_run, lo_run;
  logic [GAIN_BITS-1:0] cur_g;

  // Over-range takes priority when both comparators report at once.
  assign hi_s   = hi_sync_q[1];
  assign lo_s   = lo_sync_q[1] & ~hi_s;
  assign hi_run = all_hi_q & hi_s;
  assign lo_run = all_lo_q & lo_s;
  assign cur_g  = g_q[ch_q];

  assign ch_sel        = ch_q;
  assign gain_sel      = auto_en ? cur_g : man_gain;
  assign settled       = ena && (state_q == EVAL);
  assign sample_strobe = ena && (state_q == NEXT);
  assign overrange     = sample_strobe & ovr_q;
  assign state_dbg_o   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_sync_q <= '0;
      lo_sync_q <= '0;
    end else begin
      hi_sync_q <= {hi_sync_q[0], cmp_hi};
      lo_sync_q <= {lo_sync_q[0], cmp_lo};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ecnt_q   <= '0;
      all_hi_q <= 1'b0;
      all_lo_q <= 1'b0;
      ovr_q    <= 1'b0;
      ch_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) g_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ecnt_q   <= ecnt_d;
      all_hi_q <= all_hi_d;
      all_lo_q <= all_lo_d;
      ovr_q    <= ovr_d;
      ch_q     <= ch_d;
      for (int i = 0; i < NUM_CH; i++) g_q[i] <= g_d[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ecnt_d   = ecnt_q;
    all_hi_d = all_hi_q;
    all_lo_d = all_lo_q;
    ovr_d    = ovr_q;
    ch_d     = ch_q;
    for (int i = 0; i < NUM_CH; i++) g_d[i] = g_q[i];

    if (!ena) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d  = EVAL;
            ecnt_d   = '0;
            all_hi_d = 1'b1;
            all_lo_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        EVAL: begin
          all_hi_d = hi_run;
          all_lo_d = lo_run;
          ecnt_d   = ecnt_q + 1'b1;
          if (ecnt_q == EC_W'(HYST_COUNT - 1)) begin
            // A gain step re-settles the same channel without a strobe.
            if (auto_en && hi_run && (cur_g != '0)) begin
              g_d[ch_q] = cur_g - 1'b1;
              state_d   = SETTLE;
              cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
            end else if (auto_en && lo_run && !hi_run && (cur_g != GMAX)) begin
              g_d[ch_q] = cur_g + 1'b1;
              state_d   = SETTLE;
              cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
            end else begin
              state_d = NEXT;
              ovr_d   = hi_run && (gain_sel == '0);
            end
          end
        end
        NEXT: begin
          if (scan_en) begin
            ch_d = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
          end
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef OVR_COUNT_EN
  logic [7:0] ovr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt_q <= '0;
    end else if (overrange && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign ovr_count = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_inst_amp_gain_ctrl.sv
// Self-checking bench for inst_amp_gain_ctrl: directed scenarios plus random traffic
// checked against a phase-based reference model and a strobe scoreboard.
module tb_inst_amp_gain_ctrl;

  localparam int NUM_CH = 4;
  localparam int GB     = 3;
  localparam int S      = 16;
  localparam int H      = 4;
  localparam int GMAX   = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          cmp_hi = 1'b0;
  logic          cmp_lo = 1'b0;
  logic          auto_en = 1'b0;
  logic [GB-1:0] man_gain = '0;
  logic          scan_en = 1'b0;
  logic [1:0]    ch_sel;
  logic [GB-1:0] gain_sel;
  logic          settled;
  logic          sample_strobe;
  logic          overrange;
  logic [1:0]    state_dbg;
`ifdef OVR_COUNT_EN
  logic [7:0]    ovr_count;
`endif

  inst_amp_gain_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .cmp_hi        (cmp_hi),
    .cmp_lo        (cmp_lo),
    .auto_en       (auto_en),
    .man_gain      (man_gain),
    .scan_en       (scan_en),
    .ch_sel        (ch_sel),
    .gain_sel      (gain_sel),
    .settled       (settled),
    .sample_strobe (sample_strobe),
    .overrange     (overrange),
`ifdef OVR_COUNT_EN
    .ovr_count     (ovr_count),
`endif
    .state_dbg_o   (state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: phase -1 = idle, 0..S-1 settling, S..S+H-1 evaluating, S+H = strobe cycle.
  int       m_phase;
  int       m_g [NUM_CH];
  int       m_ch;
  int       m_ocnt;
  bit       m_s1h, m_s2h, m_s1l, m_s2l;
  bit       m_ah, m_al, m_ovr;
  int       n_cmp = 0;
  int       n_bad = 0;
  int       cyc = 0;
  logic [5:0] exp_q[$];

  function automatic void model_reset();
    m_phase = -1; m_ch = 0; m_ocnt = 0;
    for (int i = 0; i < NUM_CH; i++) m_g[i] = 0;
    m_s1h = 0; m_s2h = 0; m_s1l = 0; m_s2l = 0;
    m_ah = 0; m_al = 0; m_ovr = 0;
  endfunction

  function automatic void model_step();
    bit hi, lo;
    int gu;
    hi = m_s2h;
    lo = m_s2l && !hi;
    gu = auto_en ? m_g[m_ch] : int'(man_gain);
    if (!ena) m_phase = -1;
    else if (m_phase < 0) m_phase = 0;
    else if (m_phase < S - 1) m_phase++;
    else if (m_phase == S - 1) begin
      m_phase = S; m_ah = 1; m_al = 1;
    end else if (m_phase < S + H) begin
      m_ah = m_ah && hi;
      m_al = m_al && lo;
      if (m_phase == S + H - 1) begin
        if (auto_en && m_ah && m_g[m_ch] > 0) begin
          m_g[m_ch]--; m_phase = 0;
        end else if (auto_en && m_al && !m_ah && m_g[m_ch] < GMAX) begin
          m_g[m_ch]++; m_phase = 0;
        end else begin
          m_phase = S + H; m_ovr = m_ah && (gu == 0);
        end
      end else m_phase++;
    end else begin
      if (m_ovr && m_ocnt < 255) m_ocnt++;
      if (scan_en) m_ch = (m_ch + 1) % NUM_CH;
      m_phase = 0;
    end
    m_s2h = m_s1h; m_s1h = cmp_hi;
    m_s2l = m_s1l; m_s1l = cmp_lo;
  endfunction

  function automatic logic [15:0] exp_vec();
    logic       stb, st;
    logic [GB-1:0] gn;
    logic [7:0] oc;
    stb = ena && (m_phase == S + H);
    st  = ena && (m_phase >= S) && (m_phase < S + H);
    gn  = auto_en ? GB'(m_g[m_ch]) : man_gain;
    oc  = 8'h0;
`ifdef OVR_COUNT_EN
    oc  = 8'(m_ocnt);
`endif
    return {2'(m_ch), gn, st, stb, stb && m_ovr, oc};
  endfunction

  function automatic logic [15:0] obs_vec();
    logic [7:0] oc;
    oc = 8'h0;
`ifdef OVR_COUNT_EN
    oc = ovr_count;
`endif
    return {ch_sel, gain_sel, settled, sample_strobe, overrange, oc};
  endfunction

  task automatic tick();
    logic [15:0] e;
    @(posedge clk);
    if (rst_n) model_step();
    e = exp_vec();
    if (e[9]) exp_q.push_back({e[15:11], e[8]});
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    int  k;
    bit  seen;
    auto_en = 1; man_gain = 0; ena = 0; rst_n = 0;
    model_reset();
    #1;
    n_cmp++;
    if (obs_vec() !== 16'h0) begin
      n_bad++; $display("FAIL reset_init got=%h want=%h", obs_vec(), 16'h0);
    end
    @(negedge clk);
    rst_n = 1; ena = 1;
    repeat (18) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL reset_run cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    n_cmp++;
    if (obs_vec() !== 16'h0) begin
      n_bad++; $display("FAIL reset_async got=%h want=%h", obs_vec(), 16'h0);
    end
    repeat (2) tick();
    n_cmp++;
    if (obs_vec() !== 16'h0) begin
      n_bad++; $display("FAIL reset_hold got=%h want=%h", obs_vec(), 16'h0);
    end
    rst_n = 1;
    seen = 0; k = 0;
    while (!seen && k < 40) begin
      tick(); k++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL reset_restart cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (sample_strobe) seen = 1;
    end
    n_cmp++;
    if (!seen || k != S + H + 1) begin
      n_bad++; $display("FAIL reset_first_strobe got=%0d want=%0d", k, S + H + 1);
    end
  endtask

  task automatic test_manual_scan();
    int last, nstb, k;
    auto_en = 0; man_gain = 5; scan_en = 0; cmp_hi = 0; cmp_lo = 0;
    last = cyc;
    tick();
    scan_en = 1;
    nstb = 0; k = 0;
    while (nstb < 5 && k < 200) begin
      tick(); k++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL manual_cycle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (sample_strobe) begin
        n_cmp++;
        if (ch_sel !== 2'(nstb % NUM_CH) || gain_sel !== 3'd5 || overrange !== 1'b0 ||
            cyc - last != S + H + 1) begin
          n_bad++;
          $display("FAIL manual_strobe ch=%0d gain=%0d ovr=%b gap=%0d want ch=%0d gain=5 ovr=0 gap=%0d",
                   ch_sel, gain_sel, overrange, cyc - last, nstb % NUM_CH, S + H + 1);
        end
        last = cyc; nstb++;
      end
    end
    n_cmp++;
    if (nstb != 5) begin
      n_bad++; $display("FAIL manual_timeout got=%0d strobes want=5", nstb);
    end
    scan_en = 0;
  endtask

  task automatic test_auto_up();
    int  k;
    bit  seen;
    auto_en = 1; cmp_lo = 1; cmp_hi = 0;
    seen = 0; k = 0;
    while (!seen && k < 400) begin
      tick(); k++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL autoup_cycle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (sample_strobe) seen = 1;
    end
    n_cmp++;
    if (!seen || gain_sel !== 3'd7 || overrange !== 1'b0 || ch_sel !== 2'd0 || k != 1 + 7 * (S + H) + S + H) begin
      n_bad++;
      $display("FAIL autoup_strobe seen=%b gain=%0d ovr=%b ch=%0d cycles=%0d want gain=7 ovr=0 ch=0 cycles=%0d",
               seen, gain_sel, overrange, ch_sel, k, 1 + 7 * (S + H) + S + H);
    end
  endtask

  task automatic test_hysteresis();
    int last, nstb, k;
    cmp_lo = 0;
    last = cyc; nstb = 0; k = 0;
    while (nstb < 2 && k < 80) begin
      cmp_hi = (cyc % 4 != 0);
      tick(); k++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL hyst_cycle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (sample_strobe) begin
        n_cmp++;
        if (gain_sel !== 3'd7 || overrange !== 1'b0 || cyc - last != S + H + 1) begin
          n_bad++; $display("FAIL hyst_strobe gain=%0d ovr=%b gap=%0d want gain=7 ovr=0 gap=%0d",
                            gain_sel, overrange, cyc - last, S + H + 1);
        end
        last = cyc; nstb++;
      end
    end
    n_cmp++;
    if (nstb != 2) begin
      n_bad++; $display("FAIL hyst_timeout got=%0d strobes want=2", nstb);
    end
  endtask

  task automatic test_overrange();
    int nstb, k, target;
    scan_en = 1; cmp_hi = 1;
    tick();
    scan_en = 0;
    target = 3;
`ifdef OVR_COUNT_EN
    target = 258;
`endif
    nstb = 0; k = 0;
    while (nstb < target && k < 22 * target) begin
      tick(); k++;
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL ovr_cycle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (sample_strobe) begin
        n_cmp++;
        if (ch_sel !== 2'd1 || gain_sel !== 3'd0 || overrange !== 1'b1) begin
          n_bad++; $display("FAIL ovr_strobe ch=%0d gain=%0d ovr=%b want ch=1 gain=0 ovr=1",
                            ch_sel, gain_sel, overrange);
        end
        nstb++;
      end
    end
    n_cmp++;
    if (nstb != target) begin
      n_bad++; $display("FAIL ovr_timeout got=%0d strobes want=%0d", nstb, target);
    end
`ifdef OVR_COUNT_EN
    tick();
    n_cmp++;
    if (ovr_count !== 8'd255) begin
      n_bad++; $display("FAIL ovr_count_sat got=%0d want=255", ovr_count);
    end
`endif
  endtask

  task automatic test_dwell_ena();
    int  nstb, k;
    bit  seen;
    cmp_hi = 0; scan_en = 0;
    nstb = 0; k = 0;
    while (nstb < 2 && k < 60) begin
      tick(); k++;
      if (sample_strobe) begin
        n_cmp++;
        if (ch_sel !== 2'd1) begin
          n_bad++; $display("FAIL dwell_ch got=%0d want=1", ch_sel);
        end
        nstb++;
      end
    end
    n_cmp++;
    if (nstb != 2) begin
      n_bad++; $display("FAIL dwell_timeout got=%0d strobes want=2", nstb);
    end
    repeat (5) tick();
    ena = 0;
    repeat (30) begin
      tick();
      n_cmp++;
      if (sample_strobe !== 1'b0 || settled !== 1'b0 || ch_sel !== 2'd1 || obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL ena_off cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    ena = 1;
    seen = 0; k = 0;
    while (!seen && k < 40) begin
      tick(); k++;
      if (sample_strobe) seen = 1;
    end
    n_cmp++;
    if (!seen || k != S + H + 1 || ch_sel !== 2'd1) begin
      n_bad++; $display("FAIL ena_restart seen=%b cycles=%0d ch=%0d want cycles=%0d ch=1",
                        seen, k, ch_sel, S + H + 1);
    end
  endtask

  task automatic test_random();
    logic [5:0] e;
    exp_q.delete();
    repeat (3000) begin
      if (ena) begin
        if ($urandom_range(0, 199) == 0) ena = 0;
      end else if ($urandom_range(0, 3) == 0) ena = 1;
      if ($urandom_range(0, 15) == 0) cmp_hi = ~cmp_hi;
      if ($urandom_range(0, 11) == 0) cmp_lo = ~cmp_lo;
      if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 99) == 0) man_gain = GB'($urandom_range(0, GMAX));
      if ($urandom_range(0, 99) == 0) scan_en = ~scan_en;
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL rand_cycle cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      if (sample_strobe) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rand_sb_unexpected cyc=%0d got=%h want=none", cyc, {ch_sel, gain_sel, overrange});
        end else begin
          e = exp_q.pop_front();
          if ({ch_sel, gain_sel, overrange} !== e) begin
            n_bad++; $display("FAIL rand_sb cyc=%0d got=%h want=%h", cyc, {ch_sel, gain_sel, overrange}, e);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL rand_sb_missing got=%0d pending want=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_manual_scan();
    test_auto_up();
    test_hysteresis();
    test_overrange();
    test_dwell_ena();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
